// File: rtl/mem_responder.sv
// Single-outstanding load/store responder in front of a word-organised RAM with byte lanes.
// Define MEM_MISALIGN_TRAP_EN to fault misaligned H/HU/W accesses instead of force-aligning them.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int unsigned AW         = $clog2(DEPTH_WORDS);
    localparam logic [33:0] ADDR_LIMIT = 34'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_INIT  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt;
    logic        lat_we;
    logic [31:0] lat_addr, lat_wdata;
    logic [2:0]  lat_size;

    logic        accept, access, fault, mem_we;
    logic        a_we;
    logic [31:0] a_addr, a_wdata;
    logic [2:0]  a_size;
    logic        bad_range, bad_size, bad_align;
    logic [AW-1:0] word_idx;
    logic [1:0]  lane;
    logic [3:0]  be;
    logic [31:0] wdata_rep, rd_word, load_val;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    logic [31:0] mem [DEPTH_WORDS];

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            end
            S_WAIT: if (wait_cnt == '0) state_nxt = S_RESP;
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign accept = (state == S_IDLE) && req_valid;
    assign access = (state_nxt == S_RESP) && (state != S_RESP);

    // With zero wait the access happens on the accept edge, so use the live request fields.
    assign a_we    = (state == S_IDLE) ? req_we    : lat_we;
    assign a_addr  = (state == S_IDLE) ? req_addr  : lat_addr;
    assign a_size  = (state == S_IDLE) ? req_size  : lat_size;
    assign a_wdata = (state == S_IDLE) ? req_wdata : lat_wdata;

    assign word_idx = a_addr[2 +: AW];
    assign lane     = a_addr[1:0];

    always_comb begin
        bad_range = ({2'b00, a_addr} >= ADDR_LIMIT);
        case (a_size)
            3'b000, 3'b001, 3'b010: bad_size = 1'b0;
            3'b100, 3'b101:         bad_size = a_we;
            default:                bad_size = 1'b1;
        endcase
`ifdef MEM_MISALIGN_TRAP_EN
        bad_align = ((a_size[1:0] == 2'b01) && a_addr[0]) ||
                    ((a_size == 3'b010) && (a_addr[1:0] != 2'b00));
`else
        bad_align = 1'b0;
`endif
        fault = bad_range | bad_size | bad_align;
    end

    always_comb begin
        case (a_size[1:0])
            2'b00: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                be        = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{a_wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = a_wdata;
            end
        endcase
    end

    // Gate on reset_n so a store racing an asserted reset never reaches the array.
    assign mem_we = access && a_we && !fault && reset_n;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    assign rd_word  = mem[word_idx];
    assign byte_sel = 8'(rd_word >> {lane, 3'b000});
    assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (a_size)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_val = {24'd0, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_val = {16'd0, half_sel};
            default: load_val = rd_word;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_size   <= '0;
            lat_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_size  <= req_size;
                lat_wdata <= req_wdata;
                wait_cnt  <= WAIT_INIT;
            end else if ((state == S_WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (access) begin
                resp_err   <= fault;
                resp_rdata <= (fault || a_we) ? '0 : load_val;
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a byte-array reference model.
// Expectations follow MEM_MISALIGN_TRAP_EN when it is defined for the build.
module tb_mem_responder;
    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned WAITC   = 1;
    localparam int unsigned LAT_EXP = WAITC + 1;
    localparam int unsigned ISSUE_EXP = WAITC + 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_size = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_mem [0:4*DEPTH-1];
    logic [2:0] legal_sizes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    // Reference: memory as bytes; access width from funct3, legality from the fault rules.
    function automatic void model_access(input logic we, input logic [31:0] addr,
                                         input logic [2:0] size, input logic [31:0] wdata,
                                         output logic [31:0] rdata, output logic err);
        int unsigned n;
        int unsigned base;
        logic [31:0] v;
        rdata = '0;
        err   = 1'b0;
        case (size)
            3'd0, 3'd4: n = 1;
            3'd1, 3'd5: n = 2;
            3'd2:       n = 4;
            default:    n = 0;
        endcase
        if (n == 0 || (we && size[2])) err = 1'b1;
        if (addr >= 32'(4*DEPTH)) err = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
        if (n != 0 && (addr % n) != 0) err = 1'b1;
`endif
        if (err) return;
        base = addr - (addr % n);
        if (we) begin
            for (int unsigned i = 0; i < n; i++) model_mem[base+i] = wdata[8*i +: 8];
        end else begin
            v = '0;
            for (int unsigned i = 0; i < n; i++) v[8*i +: 8] = model_mem[base+i];
            if (!size[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            rdata = v;
        end
    endfunction

    task automatic issue(input logic we, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, output int unsigned lat, output logic tmo);
        int unsigned n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_wdata = wdata;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_size = 3'($urandom); req_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        tmo = !resp_valid || (n >= 20);
    endtask

    task automatic retire();
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic txn(input logic we, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                       output int unsigned lat, output logic tmo);
        issue(we, addr, size, wdata, lat, tmo);
        rdata = resp_rdata;
        err   = resp_err;
        retire();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", resp_err); end
    endtask

    task automatic init_ram();
        logic [31:0] r, er; logic e, ee, t; int unsigned lat;
        int tmo_cnt = 0;
        for (int unsigned i = 0; i < 4*DEPTH; i++) model_mem[i] = 8'h00;
        for (int unsigned w = 0; w < DEPTH; w++) begin
            model_access(1'b1, 32'(4*w), 3'b010, 32'h0, er, ee);
            txn(1'b1, 32'(4*w), 3'b010, 32'h0, r, e, lat, t);
            if (t || e) tmo_cnt++;
        end
        checks++; if (tmo_cnt !== 0) begin errors++; $display("FAIL init_stores: got %0d bad expected 0", tmo_cnt); end
    endtask

    task automatic test_word();
        logic [31:0] r, er; logic e, ee, t; int unsigned lat;
        model_access(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, er, ee);
        txn(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, r, e, lat, t);
        checks++; if (t || e !== 1'b0 || r !== 32'h0) begin errors++; $display("FAIL word_store: got err=%b rdata=%h tmo=%b expected err=0 rdata=0", e, r, t); end
        model_access(1'b0, 32'h10, 3'b010, 32'h0, er, ee);
        txn(1'b0, 32'h10, 3'b010, 32'h0, r, e, lat, t);
        checks++; if (t || r !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL word_load: got %h err=%b expected deadbeef err=0", r, e); end
        checks++; if (lat !== LAT_EXP) begin errors++; $display("FAIL load_latency: got %0d expected %0d", lat, LAT_EXP); end
    endtask

    task automatic test_byte();
        logic [31:0] r, er; logic e, ee, t; int unsigned lat;
        model_access(1'b1, 32'h10, 3'b010, 32'h0, er, ee);
        txn(1'b1, 32'h10, 3'b010, 32'h0, r, e, lat, t);
        model_access(1'b1, 32'h13, 3'b000, 32'h80, er, ee);
        txn(1'b1, 32'h13, 3'b000, 32'h80, r, e, lat, t);
        checks++; if (t || e !== 1'b0) begin errors++; $display("FAIL byte_store: got err=%b tmo=%b expected err=0", e, t); end
        txn(1'b0, 32'h13, 3'b000, 32'h0, r, e, lat, t);
        checks++; if (t || r !== 32'hFFFFFF80 || e !== 1'b0) begin errors++; $display("FAIL load_b: got %h expected ffffff80", r); end
        txn(1'b0, 32'h13, 3'b100, 32'h0, r, e, lat, t);
        checks++; if (t || r !== 32'h00000080 || e !== 1'b0) begin errors++; $display("FAIL load_bu: got %h expected 00000080", r); end
        txn(1'b0, 32'h10, 3'b010, 32'h0, r, e, lat, t);
        checks++; if (t || r !== 32'h80000000 || e !== 1'b0) begin errors++; $display("FAIL load_w_after_b: got %h expected 80000000", r); end
    endtask

    task automatic test_hold();
        logic [31:0] r, er, r0; logic e, ee, t; int unsigned lat;
        model_access(1'b1, 32'h40, 3'b010, 32'h12345678, er, ee);
        issue(1'b1, 32'h40, 3'b010, 32'h12345678, lat, t);
        r0 = resp_rdata;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (t || resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== r0) begin
                errors++;
                $display("FAIL hold_cycle%0d: got valid=%b ready=%b rdata=%h expected valid=1 ready=0 rdata=%h", c, resp_valid, req_ready, resp_rdata, r0);
            end
        end
        retire();
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL hold_retire: got ready=%b valid=%b expected 1/0", req_ready, resp_valid); end
        model_access(1'b0, 32'h40, 3'b010, 32'h0, er, ee);
        txn(1'b0, 32'h40, 3'b010, 32'h0, r, e, lat, t);
        checks++; if (t || r !== er || e !== ee) begin errors++; $display("FAIL hold_readback: got %h expected %h", r, er); end
    endtask

    task automatic test_range();
        logic [31:0] r, er; logic e, ee, t; int unsigned lat;
        txn(1'b0, 32'h1000, 3'b010, 32'h0, r, e, lat, t);
        checks++; if (t || e !== 1'b1 || r !== 32'h0) begin errors++; $display("FAIL range_load: got err=%b rdata=%h expected err=1 rdata=0", e, r); end
        model_access(1'b1, 32'h1000, 3'b000, 32'hAA, er, ee);
        txn(1'b1, 32'h1000, 3'b000, 32'hAA, r, e, lat, t);
        checks++; if (t || e !== 1'b1) begin errors++; $display("FAIL range_store: got err=%b expected 1", e); end
        model_access(1'b0, 32'h0, 3'b010, 32'h0, er, ee);
        txn(1'b0, 32'h0, 3'b010, 32'h0, r, e, lat, t);
        checks++; if (t || r !== er || e !== 1'b0) begin errors++; $display("FAIL range_alias: got %h expected %h", r, er); end
        txn(1'b1, 32'h0, 3'b100, 32'h55, r, e, lat, t);
        checks++; if (t || e !== 1'b1) begin errors++; $display("FAIL store_bu_illegal: got err=%b expected 1", e); end
        txn(1'b0, 32'h0, 3'b011, 32'h0, r, e, lat, t);
        checks++; if (t || e !== 1'b1 || r !== 32'h0) begin errors++; $display("FAIL size_011_illegal: got err=%b rdata=%h expected 1/0", e, r); end
    endtask

    task automatic test_misalign();
        logic [31:0] r, er, exp_r; logic e, ee, t, exp_e; int unsigned lat;
        model_access(1'b1, 32'h10, 3'b010, 32'h00008123, er, ee);
        txn(1'b1, 32'h10, 3'b010, 32'h00008123, r, e, lat, t);
`ifdef MEM_MISALIGN_TRAP_EN
        exp_r = 32'h0; exp_e = 1'b1;
`else
        exp_r = 32'hFFFF8123; exp_e = 1'b0;
`endif
        txn(1'b0, 32'h11, 3'b001, 32'h0, r, e, lat, t);
        checks++; if (t || r !== exp_r || e !== exp_e) begin errors++; $display("FAIL misalign_h: got %h err=%b expected %h err=%b", r, e, exp_r, exp_e); end
        model_access(1'b0, 32'h12, 3'b010, 32'h0, er, ee);
        txn(1'b0, 32'h12, 3'b010, 32'h0, r, e, lat, t);
        checks++; if (t || r !== er || e !== ee) begin errors++; $display("FAIL misalign_w: got %h err=%b expected %h err=%b", r, e, er, ee); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r, er; logic e, ee, t; int unsigned lat;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_size = 3'b010; req_wdata = 32'h55AA55AA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL mid_in_wait: got valid=%b ready=%b expected 0/0", resp_valid, req_ready); end
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL mid_after_reset: got ready=%b valid=%b expected 1/0", req_ready, resp_valid); end
        model_access(1'b0, 32'h20, 3'b010, 32'h0, er, ee);
        txn(1'b0, 32'h20, 3'b010, 32'h0, r, e, lat, t);
        checks++; if (t || r !== er || e !== 1'b0) begin errors++; $display("FAIL mid_old_value: got %h expected %h", r, er); end
    endtask

    task automatic test_random();
        logic [31:0] r, er, addr, wd; logic e, ee, t, we; logic [2:0] size; int unsigned lat;
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom);
            size = ($urandom_range(0, 7) == 0) ? 3'($urandom) : legal_sizes[$urandom_range(0, 4)];
            addr = ($urandom_range(0, 9) == 0) ? 32'h1000 + $urandom_range(0, 65535) : 32'($urandom_range(0, 4*DEPTH-1));
            wd = $urandom;
            model_access(we, addr, size, wd, er, ee);
            txn(we, addr, size, wd, r, e, lat, t);
            checks++;
            if (t || r !== er || e !== ee || lat !== LAT_EXP) begin
                errors++;
                $display("FAIL random%0d: we=%b addr=%h size=%0d got %h err=%b lat=%0d expected %h err=%b lat=%0d", i, we, addr, size, r, e, lat, er, ee, LAT_EXP);
            end
        end
    endtask

    task automatic test_back_to_back();
        int accepts [$];
        int n = 0;
        resp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_size = 3'b010;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (req_ready) accepts.push_back(c);
        end
        req_valid = 1'b0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        resp_ready = 1'b0;
        checks++; if (accepts.size() < 4 || n >= 20) begin errors++; $display("FAIL b2b_count: got %0d accepts expected at least 4", accepts.size()); end
        for (int k = 1; k < accepts.size() && k < 4; k++) begin
            checks++;
            if (accepts[k] - accepts[k-1] !== int'(ISSUE_EXP)) begin
                errors++;
                $display("FAIL b2b_interval%0d: got %0d expected %0d", k, accepts[k] - accepts[k-1], ISSUE_EXP);
            end
        end
    endtask

    initial begin
        test_reset();
        init_ram();
        test_word();
        test_byte();
        test_hold();
        test_range();
        test_misalign();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
